// File: rtl/beta_irq_pkg.sv
// beta_irq_pkg: shared register map, state encoding and ACTIVE layout for beta_irq_ctrl
package beta_irq_pkg;
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  // word offsets within the register window (ma[4:2])
  localparam logic [2:0] OFS_PENDING = 3'd0;
  localparam logic [2:0] OFS_MASK    = 3'd1;
  localparam logic [2:0] OFS_EDGE    = 3'd2;
  localparam logic [2:0] OFS_ACTIVE  = 3'd3;
  localparam logic [2:0] OFS_SWSET   = 3'd4;
  localparam int ACTIVE_VALID = 31;
endpackage

// File: rtl/irq_src_sync.sv
// irq_src_sync: 2-FF synchroniser for one interrupt source plus rising-edge detect
module irq_src_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise
);
  logic s1, s2, s3;
  always_ff @(posedge clk or posedge reset)
    if (reset) {s1, s2, s3} <= '0;
    else {s1, s2, s3} <= {d, s1, s2};
  assign level = s2;
  assign rise  = s2 & ~s3;
endmodule

// File: rtl/beta_irq_ctrl.sv
// beta_irq_ctrl: prioritised, vectored interrupt controller for the Beta CPU irq/xadr inputs
module beta_irq_ctrl
  import beta_irq_pkg::*;
#(
  parameter int          NSRC     = 8,
  parameter logic [31:0] REG_BASE = 32'h0000FF00,
  parameter logic [30:0] VEC_BASE = 31'h00000100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic [31:0]     ma,
  input  logic [31:0]     mdout,
  input  logic            mwe,
  output logic            irq,
  output logic [30:0]     xadr,
  output logic [31:0]     rdata,
  output logic            rsel
);
  state_t state, state_n;
  logic [NSRC-1:0] level, rise, pending, pending_n, mask, edge_cfg, req;
  logic [NSRC-1:0] sw_set, w1c, ack_clr;
  logic [3:0] id, id_n, act_id;
  logic [31:0] active_word, rd;
  logic [2:0] ofs;
  logic hit, wr, rd_cyc, ack, eoi, unused;

  for (genvar g = 0; g < NSRC; g++) begin : g_sync
    irq_src_sync u_sync (.clk(clk), .reset(reset), .d(src[g]), .level(level[g]), .rise(rise[g]));
  end

  assign hit    = ma[30:5] == REG_BASE[30:5];
  assign ofs    = ma[4:2];
  assign wr     = mwe & hit;
  assign rd_cyc = ~mwe & hit;
  assign unused = ^mdout[31:NSRC-1];
  assign req    = pending & mask;
  assign ack    = state == REQ && ma == {1'b1, xadr};
  assign eoi    = state == SERVICE && wr && ofs == OFS_ACTIVE;
  assign irq    = state == REQ;

  always_comb begin
    id_n = '0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (req[i]) id_n = 4'(i);
  end

  // sets (edge, SWSET) win over W1C and acknowledge clears in the same cycle
  assign sw_set    = (wr && ofs == OFS_SWSET) ? mdout[NSRC-1:0] : '0;
  assign w1c       = (wr && ofs == OFS_PENDING) ? mdout[NSRC-1:0] : '0;
  assign ack_clr   = ack ? (NSRC)'(1) << id : '0;
  assign pending_n = (edge_cfg & (rise | sw_set | (pending & ~(w1c | ack_clr)))) | (~edge_cfg & level);

  always_comb begin
    state_n = state;
    if (state == IDLE && |req) state_n = REQ;
    else if (ack) state_n = SERVICE;
    else if (eoi) state_n = IDLE;
  end

  always_comb begin
    active_word = 32'(act_id);
    active_word[ACTIVE_VALID] = state == SERVICE;
  end

  assign rd = ofs == OFS_PENDING ? 32'(pending) :
              ofs == OFS_MASK    ? 32'(mask) :
              ofs == OFS_EDGE    ? 32'(edge_cfg) :
              ofs == OFS_ACTIVE  ? active_word : '0;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      pending  <= '0;
      mask     <= '0;
      edge_cfg <= '0;
      id       <= '0;
      act_id   <= '0;
      xadr     <= VEC_BASE;
      rsel     <= 1'b0;
      rdata    <= '0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
      if (wr && ofs == OFS_MASK) mask <= mdout[NSRC-1:0];
      if (wr && ofs == OFS_EDGE) edge_cfg <= mdout[NSRC-1:0];
      if (state == IDLE && |req) begin
        id   <= id_n;
        xadr <= VEC_BASE + 31'({id_n, 2'b00});
      end
      if (ack) act_id <= id;
      rsel  <= rd_cyc;
      rdata <= rd_cyc ? rd : '0;
    end
endmodule

// File: tb/tb_beta_irq_ctrl.sv
// tb_beta_irq_ctrl: scenario tasks with a read-data scoreboard for beta_irq_ctrl
module tb_beta_irq_ctrl;
  logic clk = 1'b0, reset = 1'b1, mwe = 1'b0, irq, rsel;
  logic [7:0] src = '0;
  logic [31:0] ma = '0, mdout = '0, rdata;
  logic [30:0] xadr;
  logic [31:0] sb[$];
  int total = 0, bad = 0;

  beta_irq_ctrl dut (.clk(clk), .reset(reset), .src(src), .ma(ma), .mdout(mdout), .mwe(mwe),
                     .irq(irq), .xadr(xadr), .rdata(rdata), .rsel(rsel));

  always #5 clk = ~clk;

  // every task starts just after a falling edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    ma = a; mdout = d; mwe = 1'b1;
    @(negedge clk);
    ma = '0; mdout = '0; mwe = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    logic [31:0] x;
    ma = a; mwe = 1'b0; sb.push_back(e);
    @(negedge clk);
    ma = '0;
    x = sb.pop_front();
    total++;
    if (rsel !== 1'b1 || rdata !== x) begin
      bad++;
      $display("FAIL %s: rsel=%0b rdata=%h required rsel=1 rdata=%h", nm, rsel, rdata, x);
    end
  endtask

  task automatic ack_cycle(input logic [31:0] a, input string nm);
    ma = a;
    @(negedge clk);
    ma = '0;
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL %s: irq=%0b required 0", nm, irq); end
  endtask

  task automatic idle(input int n, input logic e, input string nm);
    repeat (n) @(negedge clk);
    total++;
    if (irq !== e) begin bad++; $display("FAIL %s: irq=%0b required %0b", nm, irq, e); end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++;
    if (irq !== 1'b0 || xadr !== 31'h100 || rsel !== 1'b0 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: irq=%0b xadr=%h rsel=%0b rdata=%h required 0 100 0 0", irq, xadr, rsel, rdata);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) rd(32'hFF00 + 32'(4 * i), 32'h0, "reset_reg");
  endtask

  task automatic test_edge_vector;
    int n;
    wr(32'hFF04, 32'h0C);
    wr(32'hFF08, 32'h0C);
    src = 8'h08;
    @(negedge clk);
    src = '0;
    n = 1;
    while (!irq && n < 10) begin @(negedge clk); n++; end
    total++;
    if (n !== 4 || irq !== 1'b1 || xadr !== 31'h10C) begin
      bad++;
      $display("FAIL edge_latency: cycles=%0d irq=%0b xadr=%h required 4 1 10c", n, irq, xadr);
    end
    ack_cycle(32'h8000010C, "edge_ack");
    rd(32'hFF0C, 32'h80000003, "edge_active");
    rd(32'hFF00, 32'h0, "edge_pending_cleared");
  endtask

  task automatic test_service_hold;
    src = 8'h04;
    @(negedge clk);
    src = '0;
    idle(5, 1'b0, "service_no_irq");
    rd(32'hFF00, 32'h04, "service_pending");
    wr(32'hFF0C, 32'h0);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL eoi_gap: irq=%0b required 0", irq); end
    @(negedge clk);
    total++;
    if (irq !== 1'b1 || xadr !== 31'h108) begin
      bad++;
      $display("FAIL eoi_rerequest: irq=%0b xadr=%h required 1 108", irq, xadr);
    end
    ack_cycle(32'h80000108, "service_ack");
    wr(32'hFF0C, 32'h0);
    idle(3, 1'b0, "service_quiet");
  endtask

  task automatic test_level;
    int n;
    wr(32'hFF08, 32'h0);
    wr(32'hFF04, 32'h01);
    src = 8'h01;
    n = 0;
    while (!irq && n < 10) begin @(negedge clk); n++; end
    total++;
    if (irq !== 1'b1 || xadr !== 31'h100) begin
      bad++;
      $display("FAIL level_req: irq=%0b xadr=%h required 1 100", irq, xadr);
    end
    wr(32'hFF00, 32'h01);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL level_w1c_irq: irq=%0b required 1", irq); end
    rd(32'hFF00, 32'h01, "level_w1c_pending");
    src = '0;
    idle(4, 1'b1, "level_drop_in_req");
    rd(32'hFF00, 32'h0, "level_drop_pending");
    ack_cycle(32'h80000100, "level_ack");
    rd(32'hFF0C, 32'h80000000, "level_active");
    wr(32'hFF0C, 32'h0);
    idle(3, 1'b0, "level_quiet");
    rd(32'hFF0C, 32'h0, "level_active_cleared");
  endtask

  task automatic test_back_to_back;
    wr(32'hFF08, 32'h80);
    wr(32'hFF04, 32'h80);
    wr(32'hFF10, 32'h80);
    wr(32'hFF00, 32'h80);
    total++;
    if (irq !== 1'b1 || xadr !== 31'h11C) begin
      bad++;
      $display("FAIL swset_req: irq=%0b xadr=%h required 1 11c", irq, xadr);
    end
    idle(2, 1'b1, "swset_no_retract");
    rd(32'hFF00, 32'h0, "swset_w1c_pending");
    ack_cycle(32'h8000011C, "swset_ack");
    wr(32'hFF0C, 32'h0);
    idle(4, 1'b0, "swset_no_rerequest");
  endtask

  task automatic test_unused;
    wr(32'hFF14, 32'hFFFFFFFF);
    total++;
    if (rsel !== 1'b0) begin bad++; $display("FAIL write_no_rsel: rsel=%0b required 0", rsel); end
    rd(32'hFF04, 32'h80, "unused_mask_kept");
    rd(32'hFF14, 32'h0, "unused_read");
    rd(32'hFF10, 32'h0, "swset_read");
    ma = 32'h1000;
    @(negedge clk);
    ma = '0;
    total++;
    if (rsel !== 1'b0 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL miss_read: rsel=%0b rdata=%h required 0 0", rsel, rdata);
    end
  endtask

  task automatic test_async_reset;
    wr(32'hFF10, 32'h80);
    @(negedge clk);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL pre_reset_req: irq=%0b required 1", irq); end
    #2 reset = 1'b1;
    #1;
    total++;
    if (irq !== 1'b0 || xadr !== 31'h100) begin
      bad++;
      $display("FAIL async_reset: irq=%0b xadr=%h required 0 100", irq, xadr);
    end
    @(negedge clk);
    reset = 1'b0;
    rd(32'hFF04, 32'h0, "reset_mask");
    rd(32'hFF08, 32'h0, "reset_edge");
  endtask

  initial begin
    test_reset;
    test_edge_vector;
    test_service_hold;
    test_level;
    test_back_to_back;
    test_unused;
    test_async_reset;
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL scoreboard_drain: left=%0d required 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
